// File: rtl/instruction_prefetch.sv
// Fetch stage: walks a sequential PC, issues one-word reads to the memory
// instruction port and buffers responses with their PC for decode.
module instruction_prefetch #(
    parameter logic [31:0] RESET_PC   = 32'h0,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] i_address,
    output logic        i_is_read,
    input  logic [31:0] i_read_data,
    input  logic        i_ready,
    input  logic        branch_valid,
    input  logic [31:0] branch_target,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_accept
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   req_pc_q, req_pc_d;
    logic          pending_q, pending_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [31:0]   word_mem_q [FIFO_DEPTH];
    logic [31:0]   pc_mem_q   [FIFO_DEPTH];

    logic [CW-1:0] occupancy;
    logic          issue;
    logic          push;
    logic          pop;

    always_comb begin
        // In-flight requests reserve a slot; pops this cycle are not credited.
        occupancy = count_q + CW'(pending_q);
        issue     = !reset && !branch_valid && (occupancy < DEPTH_C);
        push      = i_ready && pending_q && !branch_valid;
        pop       = (count_q != '0) && inst_accept && !branch_valid;

        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        pending_d  = issue;
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;

        if (branch_valid) begin
            fetch_pc_d = branch_target & 32'hFFFF_FFFC;
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
        end else begin
            if (issue) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
                req_pc_d   = fetch_pc_q;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (!push && pop) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= RESET_PC;
            pending_q  <= 1'b0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            pending_q  <= pending_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // Payload storage carries no reset; validity lives entirely in count_q.
    always_ff @(posedge clock) begin
        if (push) begin
            word_mem_q[wr_ptr_q] <= i_read_data;
            pc_mem_q[wr_ptr_q]   <= req_pc_q;
        end
    end

    assign i_address  = fetch_pc_q;
    assign i_is_read  = issue;
    assign inst_valid = (count_q != '0);
    assign inst       = word_mem_q[rd_ptr_q];
    assign inst_pc    = pc_mem_q[rd_ptr_q];

    overflow_chk: assert property (@(posedge clock) disable iff (reset)
        !(push && !pop && (count_q == DEPTH_C)));

endmodule

// File: tb/tb_instruction_prefetch.sv
// Bench for instruction_prefetch: a queue-based model of delivered PCs checks
// every cycle under directed scenarios followed by randomized traffic.
module tb_instruction_prefetch;

    localparam logic [31:0] RESET_PC   = 32'h0;
    localparam int          FIFO_DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] i_address;
    logic        i_is_read;
    logic [31:0] i_read_data;
    logic        i_ready;
    logic        branch_valid = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_accept = 1'b0;

    logic        mem_rdy  = 1'b0;
    logic [31:0] mem_addr = 32'h0;
    logic        spurious = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_q[$];
    logic        inflight    = 1'b0;
    logic [31:0] inflight_pc = 32'h0;
    logic [31:0] m_pc        = RESET_PC;

    instruction_prefetch #(.RESET_PC(RESET_PC), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clock        (clock),
        .reset        (reset),
        .i_address    (i_address),
        .i_is_read    (i_is_read),
        .i_read_data  (i_read_data),
        .i_ready      (i_ready),
        .branch_valid (branch_valid),
        .branch_target(branch_target),
        .inst_valid   (inst_valid),
        .inst         (inst),
        .inst_pc      (inst_pc),
        .inst_accept  (inst_accept)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] memword(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_3C3C;
    endfunction

    // Memory answers every request exactly one cycle later.
    always @(posedge clock) begin
        mem_rdy  <= i_is_read;
        mem_addr <= i_address;
    end
    assign i_ready     = mem_rdy | spurious;
    assign i_read_data = memword(mem_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        inflight = 1'b0;
        m_pc     = RESET_PC;
    endtask

    task automatic body(input logic bv, input logic [31:0] tgt, input logic acc, input logic spur);
        logic exp_issue;
        logic exp_valid;
        branch_valid  = bv;
        branch_target = tgt;
        inst_accept   = acc;
        spurious      = spur;
        #1;
        exp_issue = !bv && ((exp_q.size() + (inflight ? 1 : 0)) < FIFO_DEPTH);
        exp_valid = (exp_q.size() != 0);
        chk("i_is_read", {31'b0, i_is_read}, {31'b0, exp_issue});
        chk("i_address", i_address, m_pc);
        chk("inst_valid", {31'b0, inst_valid}, {31'b0, exp_valid});
        if (exp_valid) begin
            chk("inst_pc", inst_pc, exp_q[0]);
            chk("inst", inst, memword(exp_q[0]));
        end
        if (bv) begin
            exp_q.delete();
            inflight = 1'b0;
            m_pc     = tgt & 32'hFFFF_FFFC;
        end else begin
            if (exp_valid && acc) void'(exp_q.pop_front());
            if (inflight) exp_q.push_back(inflight_pc);
            inflight    = exp_issue;
            inflight_pc = m_pc;
            if (exp_issue) m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic step(input logic bv, input logic [31:0] tgt, input logic acc);
        @(negedge clock);
        body(bv, tgt, acc, 1'b0);
    endtask

    task automatic guard_chk(input string tag, input int guard, input int limit);
        n_checks++;
        assert (guard < limit) else begin
            n_fail++;
            $error("FAIL %s observed=%0d cycles required<%0d", tag, guard, limit);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        logic bv;
        logic acc;
        logic spur;
        logic [31:0] tgt;

        // Reset state
        #1 reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_i_is_read", {31'b0, i_is_read}, 32'h0);
        chk("rst_inst_valid", {31'b0, inst_valid}, 32'h0);
        chk("rst_i_address", i_address, RESET_PC);
        model_reset();
        @(negedge clock);
        reset = 1'b0;
        body(1'b0, 32'h0, 1'b1, 1'b0);

        // Streaming with decode always accepting
        repeat (12) step(1'b0, 32'h0, 1'b1);

        // Decode stalls, FIFO fills, then drains in order
        repeat (10) step(1'b0, 32'h0, 1'b0);
        repeat (10) step(1'b0, 32'h0, 1'b1);

        // Branch with three buffered and one in flight
        guard = 0;
        while (!(exp_q.size() == 3 && inflight) && guard < 20) begin
            step(1'b0, 32'h0, 1'b0);
            guard++;
        end
        guard_chk("reach_3_buffered", guard, 20);
        step(1'b1, 32'h0000_0103, 1'b0);
        repeat (8) step(1'b0, 32'h0, 1'b1);

        // Branch coincident with a response and an accept
        guard = 0;
        while (!(exp_q.size() != 0 && inflight) && guard < 20) begin
            step(1'b0, 32'h0, 1'b1);
            guard++;
        end
        guard_chk("reach_busy", guard, 20);
        step(1'b1, 32'h0000_0200, 1'b1);
        repeat (6) step(1'b0, 32'h0, 1'b1);

        // Back-to-back branches, last one wins, then address wrap
        step(1'b1, 32'h0000_0300, 1'b1);
        step(1'b1, 32'hFFFF_FFF8, 1'b1);
        repeat (8) step(1'b0, 32'h0, 1'b1);

        // Asynchronous reset with two entries buffered
        guard = 0;
        while (exp_q.size() < 2 && guard < 20) begin
            step(1'b0, 32'h0, 1'b0);
            guard++;
        end
        guard_chk("reach_2_buffered", guard, 20);
        @(negedge clock);
        branch_valid = 1'b0;
        inst_accept  = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("async_i_is_read", {31'b0, i_is_read}, 32'h0);
        chk("async_inst_valid", {31'b0, inst_valid}, 32'h0);
        chk("async_i_address", i_address, RESET_PC);
        model_reset();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        body(1'b0, 32'h0, 1'b1, 1'b1);
        repeat (8) step(1'b0, 32'h0, 1'b1);

        // Randomized traffic: mostly-accepting, then mostly-stalled decode
        for (int phase = 0; phase < 2; phase++) begin
            for (int i = 0; i < 200; i++) begin
                bv = ($urandom_range(0, 15) == 0);
                tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                  : $urandom;
                acc = (phase == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
                spur = !inflight && ($urandom_range(0, 1) == 1);
                @(negedge clock);
                body(bv, tgt, acc, spur);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
